// File: rtl/shifter_pkg.sv
// Shared types and constants for the sequential right shifter.
// SHAMT_W is the number of binary-weighted stages for the default 32-bit datapath.
package shifter_pkg;

    localparam int N_DEFAULT = 32;
    localparam int SHAMT_W   = $clog2(N_DEFAULT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_right_stage.sv
// One binary-weighted right-shift stage: shifts by 2^stage when enabled,
// filling the vacated upper bits with fill; otherwise passes data through.
module shift_right_stage #(
    parameter int N  = 32,
    parameter int SW = $clog2(N)
) (
    input  logic [N-1:0]  i_data,
    input  logic [SW-1:0] i_stage,
    input  logic          i_enable,
    input  logic          i_fill,
    output logic [N-1:0]  o_data
);

    logic [N-1:0] w_ones;
    logic [N-1:0] w_fill_mask;
    logic [N-1:0] w_shifted;

    always_comb begin
        w_ones      = '1;
        // Ones exactly in the 2^stage positions vacated at the top.
        w_fill_mask = ~(w_ones >> (1 << i_stage));
        w_shifted   = (i_data >> (1 << i_stage)) | (i_fill ? w_fill_mask : '0);
        o_data      = i_enable ? w_shifted : i_data;
    end

endmodule

// File: rtl/shift_right_seq.sv
// Multi-cycle logical/arithmetic right shifter: one binary-weighted stage per clock,
// valid/ready on both sides, fixed SHAMT_W-cycle latency regardless of shift amount.
module shift_right_seq
    import shifter_pkg::*;
#(
    parameter int N       = 32,
    parameter int SHAMT_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N-1:0]       in,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               arith,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N-1:0]       out,
    output state_t             dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
    // in_ready and out_valid depend only on registered state, never on the partner's signal.

    localparam logic [SHAMT_W-1:0] LAST_STAGE = SHAMT_W'(SHAMT_W - 1);

    state_t               r_state;
    state_t               w_next_state;
    logic [SHAMT_W-1:0]   r_stage;
    logic [SHAMT_W-1:0]   r_shamt;
    logic [N-1:0]         r_work;
    logic [N-1:0]         r_out;
    logic                 r_fill;
    logic [N-1:0]         w_shifted;
    logic                 w_accept;
    logic                 w_last;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign out       = r_out;
    assign dbg_state = r_state;
    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_stage == LAST_STAGE);

    shift_right_stage #(
        .N  (N),
        .SW (SHAMT_W)
    ) u_stage (
        .i_data   (r_work),
        .i_stage  (r_stage),
        .i_enable (r_shamt[r_stage]),
        .i_fill   (r_fill),
        .o_data   (w_shifted)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_next_state = SHIFT;
            SHIFT:   if (w_last)    w_next_state = DONE;
            DONE:    if (out_ready) w_next_state = IDLE;
            default:                w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // The result is captured into r_out on the final stage so out stays put
    // while the working register is reloaded by the next operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage <= '0;
            r_shamt <= '0;
            r_work  <= '0;
            r_fill  <= 1'b0;
            r_out   <= '0;
        end else if (w_accept) begin
            r_stage <= '0;
            r_shamt <= shamt;
            r_work  <= in;
            r_fill  <= arith & in[N-1];
        end else if (r_state == SHIFT) begin
            r_work  <= w_shifted;
            r_stage <= r_stage + 1'b1;
            if (w_last) begin
                r_out <= w_shifted;
            end
        end
    end

endmodule

// File: tb/tb_shift_right_seq.sv
// Directed bench for shift_right_seq: driver issues operations and queues expected
// results; an independent monitor pops and compares on every output handshake.
module tb_shift_right_seq;
  import shifter_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        tb_in_valid;
  logic        tb_in_ready;
  logic [31:0] tb_in;
  logic [4:0]  tb_shamt;
  logic        tb_arith;
  logic        tb_out_valid;
  logic        tb_out_ready;
  logic [31:0] tb_out;
  state_t      tb_dbg_state;

  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  shift_right_seq #(.N(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (tb_in_valid),
    .in_ready  (tb_in_ready),
    .in        (tb_in),
    .shamt     (tb_shamt),
    .arith     (tb_arith),
    .out_valid (tb_out_valid),
    .out_ready (tb_out_ready),
    .out       (tb_out),
    .dbg_state (tb_dbg_state)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && tb_out_valid && tb_out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", tb_out, 32'hxxxx_xxxx);
      end else begin
        check("result", tb_out, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic wait_ready(input string name);
    int t = 0;
    while (!tb_in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 100) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Drives one operation; returns after the acceptance edge (+1 time unit).
  task automatic send(input logic [31:0] d, input logic [4:0] s, input logic a,
                      input logic [31:0] e);
    @(posedge clk); #1;
    tb_in = d; tb_shamt = s; tb_arith = a; tb_in_valid = 1'b1;
    wait_ready("accept");
    @(posedge clk);
    exp_q.push_back(e);
    #1;
    tb_in_valid = 1'b0;
    tb_in    = $urandom;
    tb_shamt = 5'($urandom_range(0, 31));
    tb_arith = 1'($urandom_range(0, 1));
  endtask

  task automatic run_op(input logic [31:0] d, input logic [4:0] s, input logic a,
                        input logic [31:0] e);
    send(d, s, a, e);
    wait_ready("complete");
  endtask

  logic [31:0] bp_exp;

  initial begin
    tb_in_valid = 1'b0; tb_in = '0; tb_shamt = '0; tb_arith = 1'b0; tb_out_ready = 1'b1;
    rst_n = 1'b0;
    #22;
    rst_n = 1'b1;
    #1;
    check("reset_out_valid", 32'(tb_out_valid), 32'd0);
    check("reset_in_ready", 32'(tb_in_ready), 32'd1);
    check("reset_out", tb_out, 32'h0000_0000);

    // logical shift with exact latency: out_valid exactly 5 edges after acceptance
    send(32'h8000_0000, 5'd4, 1'b0, 32'h0800_0000);
    for (int k = 1; k <= 5; k++) begin
      check($sformatf("lat_out_valid_low_%0d", k), 32'(tb_out_valid), 32'd0);
      check($sformatf("lat_in_ready_low_%0d", k), 32'(tb_in_ready), 32'd0);
      @(posedge clk); #1;
    end
    check("lat_out_valid_high", 32'(tb_out_valid), 32'd1);
    check("lat_out_value", tb_out, 32'h0800_0000);
    wait_ready("complete");

    run_op(32'hF000_0000, 5'd8,  1'b1, 32'hFFF0_0000);
    run_op(32'hF000_0000, 5'd8,  1'b0, 32'h00F0_0000);
    run_op(32'hDEAD_BEEF, 5'd0,  1'b1, 32'hDEAD_BEEF);
    run_op(32'h8000_0001, 5'd31, 1'b1, 32'hFFFF_FFFF);
    run_op(32'h8000_0001, 5'd31, 1'b0, 32'h0000_0001);
    run_op(32'h1234_5678, 5'd12, 1'b1, 32'h0001_2345);
    run_op(32'h1234_5678, 5'd12, 1'b0, 32'h0001_2345);
    run_op(32'hA5A5_A5A5, 5'd19, 1'b1, 32'hFFFF_F4B4);
    run_op(32'h7FFF_FFFF, 5'd31, 1'b1, 32'h0000_0000);

    // backpressure: result held, no acceptance while busy
    tb_out_ready = 1'b0;
    bp_exp = 32'h000F_F000;
    send(32'h00FF_0000, 5'd4, 1'b0, bp_exp);
    begin
      int t = 0;
      while (!tb_out_valid && t < 50) begin
        @(posedge clk); #1;
        t++;
      end
      check("bp_wait_valid", 32'(tb_out_valid), 32'd1);
    end
    for (int k = 0; k < 10; k++) begin
      tb_in_valid = ~tb_in_valid;
      tb_in = $urandom;
      @(posedge clk); #1;
      check("bp_out_stable", tb_out, bp_exp);
      check("bp_out_valid_held", 32'(tb_out_valid), 32'd1);
      check("bp_in_ready_low", 32'(tb_in_ready), 32'd0);
    end
    tb_in_valid = 1'b0;
    tb_out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_in_ready_after", 32'(tb_in_ready), 32'd1);
    check("bp_out_valid_after", 32'(tb_out_valid), 32'd0);
    check("bp_out_retained", tb_out, bp_exp);

    // reset two edges after acceptance discards the operation
    send(32'hFFFF_FFFF, 5'd1, 1'b0, 32'h7FFF_FFFF);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_out", tb_out, 32'h0000_0000);
    check("midrst_out_valid", 32'(tb_out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'h0000_FF00, 5'd8, 1'b0, 32'h0000_00FF);

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
